// File: rtl/mish_req_arbiter.sv
// mish_req_arbiter: round-robin front end that shares one Mish datapath
// between NUM_REQ requesters. It accepts one operand, holds it on core_in for
// CORE_LAT cycles, captures core_out and returns it tagged with the requester
// id over a valid/ready response port.
module mish_req_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int IN_W     = 12,
  parameter int OUT_W    = 32,
  parameter int CORE_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*IN_W-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [IN_W-1:0]         core_in,
  input  logic [OUT_W-1:0]        core_out,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [OUT_W-1:0]        rsp_data,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    busy
);

  localparam int CNT_W = $clog2(CORE_LAT + 1);
  // One extra bit so last_grant + offset cannot overflow before the wrap.
  localparam int CW    = ID_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IN_W-1:0]  core_in_q, core_in_d;
  logic [OUT_W-1:0] rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_valid_q, rsp_valid_d;

  logic [NUM_REQ-1:0][IN_W-1:0] req_op;
  logic                         gnt_any;
  logic [ID_W-1:0]              gnt_idx;
  logic [CW-1:0]                cand;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_op[k] = req_data[k*IN_W +: IN_W];
  end

  // Round-robin search: first valid requester after last_grant, wrapping.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = last_grant_q;
    cand    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, last_grant_q} + CW'(i);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!gnt_any && req_valid[cand[ID_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[ID_W-1:0];
      end
    end
  end

  // Grant is only offered in IDLE, and never while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == S_IDLE) && gnt_any)
      req_ready = NUM_REQ'(1) << gnt_idx;
  end

  // FSM next state: IDLE grants, WAIT counts down the core latency, RESP holds.
  always_comb begin
    state_d      = state_q;
    core_in_d    = core_in_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          core_in_d    = req_op[gnt_idx];
          rsp_id_d     = gnt_idx;
          last_grant_d = gnt_idx;
          cnt_d        = CNT_W'(CORE_LAT);
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          rsp_data_d  = core_out;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        // Acceptance returns to IDLE only; the next grant waits a cycle.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      core_in_q    <= '0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      core_in_q    <= core_in_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  assign core_in   = core_in_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mish_req_arbiter.sv
// tb_mish_req_arbiter: directed bench for the Mish request arbiter. A
// stand-in combinational core feeds core_out; one instance runs with
// CORE_LAT=1, a second with CORE_LAT=3 for latency and mid-WAIT reset.
module tb_mish_req_arbiter;
  localparam int NR  = 4;
  localparam int IDW = 2;
  localparam int IW  = 12;
  localparam int OW  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b1, rst_n3 = 1'b1;
  logic [NR-1:0]     req_valid = '0, req_valid3 = '0, req_ready, req_ready3;
  logic [NR*IW-1:0]  req_data = '0, req_data3 = '0;
  logic [IW-1:0]     core_in, core_in3;
  logic [OW-1:0]     core_out, core_out3, rsp_data, rsp_data3;
  logic              rsp_valid, rsp_valid3, busy, busy3;
  logic              rsp_ready = 1'b0, rsp_ready3 = 1'b0;
  logic [IDW-1:0]    rsp_id, rsp_id3;

  int n_chk = 0;
  int n_bad = 0;

  // Stand-in core: the known Mish value for 1.0, otherwise a distinct
  // sign-extended scaling of the code (0 maps to 0).
  function automatic logic [OW-1:0] core_model(input logic [IW-1:0] x);
    logic signed [OW-1:0] s;
    if (x == 12'h080) return 32'h0000DD78;
    s = {{(OW-IW){x[IW-1]}}, x};
    return s * 32'sd373;
  endfunction

  assign core_out  = core_model(core_in);
  assign core_out3 = core_model(core_in3);

  mish_req_arbiter #(.NUM_REQ(NR), .ID_W(IDW), .IN_W(IW), .OUT_W(OW), .CORE_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .core_in(core_in), .core_out(core_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .busy(busy));

  mish_req_arbiter #(.NUM_REQ(NR), .ID_W(IDW), .IN_W(IW), .OUT_W(OW), .CORE_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n3), .req_valid(req_valid3), .req_data(req_data3),
    .req_ready(req_ready3), .core_in(core_in3), .core_out(core_out3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3),
    .rsp_id(rsp_id3), .busy(busy3));

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full op on the CORE_LAT=1 instance, starting in an IDLE cycle with
  // req_valid/req_data already driven and rsp_ready=1.
  task automatic run_op(input string p, input int k, input logic [IW-1:0] d);
    logic [NR-1:0] oh;
    oh = NR'(1) << k;
    #1;
    chk({p, "_grant"}, req_ready, oh);
    chk({p, "_idle_vld"}, rsp_valid, 0);
    tick();
    chk({p, "_wait_rdy"}, req_ready, 0);
    chk({p, "_wait_vld"}, rsp_valid, 0);
    chk({p, "_busy"}, busy, 1);
    chk({p, "_core_in"}, core_in, d);
    tick();
    chk({p, "_rsp_vld"}, rsp_valid, 1);
    chk({p, "_rsp_id"}, rsp_id, k);
    chk({p, "_rsp_data"}, rsp_data, core_model(d));
    tick();
    chk({p, "_done_vld"}, rsp_valid, 0);
    chk({p, "_done_busy"}, busy, 0);
  endtask

  initial begin
    logic [IW-1:0] rrd [NR];
    rrd = '{12'h101, 12'h222, 12'h7ff, 12'h800};

    // Reset with every requester asking: nothing may be granted.
    req_valid  = 4'b1111;
    req_valid3 = 4'b1111;
    #2;
    rst_n  = 1'b0;
    rst_n3 = 1'b0;
    tick();
    tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_vld", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_core_in", core_in, 0);
    chk("rst3_ready", req_ready3, 0);
    chk("rst3_busy", busy3, 0);
    req_valid  = '0;
    req_valid3 = '0;
    rst_n = 1'b1;
    tick();

    // Single op from requester 2: 1.0 then 0.0.
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    req_data[2*IW +: IW] = 12'h080;
    run_op("one", 2, 12'h080);
    req_data[2*IW +: IW] = 12'h000;
    run_op("zero", 2, 12'h000);
    req_valid = '0;
    tick();

    // Round-robin from a fresh reset with all four valid.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < NR; k++) req_data[k*IW +: IW] = rrd[k];
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) run_op("rr", n % NR, rrd[n % NR]);

    // Backpressure: requester 1 alone, response stalled.
    req_valid = 4'b0010;
    req_data[IW +: IW] = 12'h123;
    rsp_ready = 1'b0;
    #1;
    chk("bp_grant", req_ready, 4'b0010);
    tick();
    req_valid = 4'b1111;
    #1;
    chk("bp_busy", busy, 1);
    tick();
    chk("bp_vld", rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_vld", rsp_valid, 1);
      chk("bp_hold_data", rsp_data, core_model(12'h123));
      chk("bp_hold_id", rsp_id, 1);
      chk("bp_hold_rdy", req_ready, 0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", req_ready, 0);
    tick();
    chk("bp_idle_vld", rsp_valid, 0);
    chk("bp_idle_busy", busy, 0);
    req_data[IW +: IW] = 12'h7ff;
    run_op("bp_next", 2, rrd[2]);
    req_valid = '0;
    tick();

    // CORE_LAT=3: full latency, then reset in the middle of WAIT.
    rst_n3 = 1'b1;
    rsp_ready3 = 1'b1;
    tick();
    req_valid3 = 4'b0010;
    req_data3[IW +: IW] = 12'h055;
    #1;
    chk("l3_grant", req_ready3, 4'b0010);
    tick();
    req_valid3 = '0;
    #1;
    chk("l3_busy", busy3, 1);
    chk("l3_t1", rsp_valid3, 0);
    tick();
    chk("l3_t2", rsp_valid3, 0);
    tick();
    chk("l3_t3", rsp_valid3, 0);
    tick();
    chk("l3_t4_vld", rsp_valid3, 1);
    chk("l3_t4_data", rsp_data3, core_model(12'h055));
    chk("l3_t4_id", rsp_id3, 1);
    tick();
    chk("l3_done", rsp_valid3, 0);
    req_valid3 = 4'b0100;
    req_data3[2*IW +: IW] = 12'h0aa;
    #1;
    chk("mr_grant", req_ready3, 4'b0100);
    tick();
    req_valid3 = '0;
    tick();
    chk("mr_busy_pre", busy3, 1);
    rst_n3 = 1'b0;
    #1;
    chk("mr_busy", busy3, 0);
    chk("mr_vld", rsp_valid3, 0);
    chk("mr_core_in", core_in3, 0);
    tick();
    rst_n3 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mr_no_rsp", rsp_valid3, 0);
      chk("mr_idle", busy3, 0);
    end
    req_valid3 = 4'b1111;
    #1;
    chk("mr_first", req_ready3, 4'b0001);
    tick();
    req_valid3 = '0;

    // Sweep requester 0 across -1280..+1280.
    req_valid = 4'b0001;
    for (int c = -1280; c <= 1280; c++) begin
      req_data[0 +: IW] = IW'(c);
      run_op("sweep", 0, IW'(c));
    end
    req_valid = '0;
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
